// File: rtl/clk_enable_gen_pkg.sv
// Shared types and helpers for the multi-channel NCO clock-enable generator.
// Holds the control FSM state type and the unpacker for packed per-channel defaults.
package clk_enable_gen_pkg;

    localparam int unsigned MAX_CHANNELS  = 16;
    localparam int unsigned MAX_ACC_WIDTH = 64;
    localparam int unsigned PACK_W        = MAX_CHANNELS * MAX_ACC_WIDTH;

    typedef enum logic [1:0] {
        LOCKING,
        LOCKED,
        APPLY
    } cegen_state_e;

    // Extracts channel idx (width bits, channel 0 in the LSBs) from a packed default vector.
    function automatic logic [MAX_ACC_WIDTH-1:0] chan_field(
        input logic [PACK_W-1:0] vec,
        input int unsigned       idx,
        input int unsigned       width
    );
        logic [PACK_W-1:0]        shifted;
        logic [MAX_ACC_WIDTH-1:0] field;
        shifted = vec >> (idx * width);
        field   = '0;
        for (int unsigned b = 0; b < MAX_ACC_WIDTH; b++) begin
            if (b < width) begin
                field[b] = shifted[b];
            end
        end
        return field;
    endfunction

endpackage

// File: rtl/cegen_channel.sv
// One NCO channel: increment/phase registers, phase accumulator and registered ce/clk outputs.
// The accumulator either steps (run), reloads its phase (realign) or holds.
module cegen_channel
    import clk_enable_gen_pkg::*;
#(
    parameter int unsigned            ACC_WIDTH = 32,
    parameter logic [ACC_WIDTH-1:0]   DEF_INCR  = '0,
    parameter logic [ACC_WIDTH-1:0]   DEF_PHASE = '0
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 load_i,
    input  logic [ACC_WIDTH-1:0] load_incr_i,
    input  logic [ACC_WIDTH-1:0] load_phase_i,
    input  logic                 realign_i,
    input  logic                 run_i,
    output logic                 ce_o,
    output logic                 clk_o
);

    logic [ACC_WIDTH-1:0] incr_q, incr_d;
    logic [ACC_WIDTH-1:0] phase_q, phase_d;
    logic [ACC_WIDTH-1:0] acc_q, acc_d;
    logic                 ce_q, ce_d;
    logic                 clk_q, clk_d;
    logic [ACC_WIDTH:0]   sum;

    assign sum = {1'b0, acc_q} + {1'b0, incr_q};

    always_comb begin
        incr_d  = incr_q;
        phase_d = phase_q;
        acc_d   = acc_q;
        ce_d    = 1'b0;
        clk_d   = clk_q;
        if (load_i) begin
            incr_d  = load_incr_i;
            phase_d = load_phase_i;
        end
        if (realign_i) begin
            acc_d = phase_q;
            clk_d = phase_q[ACC_WIDTH-1];
        end else if (run_i && (incr_q != '0)) begin
            // A zero increment freezes the channel: no pulse, square wave keeps its level.
            acc_d = sum[ACC_WIDTH-1:0];
            ce_d  = sum[ACC_WIDTH];
            clk_d = sum[ACC_WIDTH-1];
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            incr_q  <= DEF_INCR;
            phase_q <= DEF_PHASE;
            acc_q   <= DEF_PHASE;
            ce_q    <= 1'b0;
            clk_q   <= 1'b0;
        end else begin
            incr_q  <= incr_d;
            phase_q <= phase_d;
            acc_q   <= acc_d;
            ce_q    <= ce_d;
            clk_q   <= clk_d;
        end
    end

    assign ce_o  = ce_q;
    assign clk_o = clk_q;

endmodule

// File: rtl/clk_enable_gen.sv
// Multi-channel fractional clock-enable generator: per-channel NCOs, runtime config port,
// realignment of all channels after each write and a lock qualifier.
module clk_enable_gen
    import clk_enable_gen_pkg::*;
#(
    parameter int unsigned                          NUM_CHANNELS  = 6,
    parameter int unsigned                          ACC_WIDTH     = 32,
    parameter int unsigned                          LOCK_CYCLES   = 16,
    parameter logic [NUM_CHANNELS*ACC_WIDTH-1:0]    DEFAULT_INCR  = '0,
    parameter logic [NUM_CHANNELS*ACC_WIDTH-1:0]    DEFAULT_PHASE = '0
) (
    input  logic                                                   refclk,
    input  logic                                                   rst,
    input  logic                                                   cfg_valid,
    output logic                                                   cfg_ready,
    input  logic [((NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1)-1:0] cfg_chan,
    input  logic [ACC_WIDTH-1:0]                                   cfg_incr,
    input  logic [ACC_WIDTH-1:0]                                   cfg_phase,
    output logic [NUM_CHANNELS-1:0]                                ce_o,
    output logic [NUM_CHANNELS-1:0]                                clk_o,
    output logic                                                   locked
);

    localparam int unsigned CHAN_W = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;
    localparam int unsigned LOCK_W = $clog2(LOCK_CYCLES + 1);
    localparam logic [LOCK_W-1:0] LOCK_LAST = LOCK_W'(LOCK_CYCLES - 1);

    cegen_state_e      state_q, state_d;
    logic [LOCK_W-1:0] lock_cnt_q, lock_cnt_d;
    logic              locked_q, locked_d;
    logic              in_range;
    logic              cfg_write;

    generate
        if (NUM_CHANNELS == (1 << CHAN_W)) begin : g_full_range
            assign in_range = 1'b1;
        end else begin : g_partial_range
            assign in_range = (cfg_chan < CHAN_W'(NUM_CHANNELS));
        end
    endgenerate

    assign cfg_ready = ~rst & (state_q != APPLY);
    // Out-of-range writes complete the handshake but touch nothing.
    assign cfg_write = cfg_valid & cfg_ready & in_range;

    always_comb begin
        state_d    = state_q;
        lock_cnt_d = lock_cnt_q;
        locked_d   = locked_q;
        unique case (state_q)
            LOCKING: begin
                if (cfg_write) begin
                    state_d    = APPLY;
                    locked_d   = 1'b0;
                    lock_cnt_d = '0;
                end else if (lock_cnt_q == LOCK_LAST) begin
                    state_d  = LOCKED;
                    locked_d = 1'b1;
                end else begin
                    lock_cnt_d = lock_cnt_q + 1'b1;
                end
            end
            LOCKED: begin
                if (cfg_write) begin
                    state_d  = APPLY;
                    locked_d = 1'b0;
                end
            end
            APPLY: begin
                state_d    = LOCKING;
                lock_cnt_d = '0;
            end
            default: begin
                state_d    = LOCKING;
                lock_cnt_d = '0;
                locked_d   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            state_q    <= LOCKING;
            lock_cnt_q <= '0;
            locked_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            lock_cnt_q <= lock_cnt_d;
            locked_q   <= locked_d;
        end
    end

    assign locked = locked_q;

    generate
        for (genvar i = 0; i < NUM_CHANNELS; i++) begin : g_chan
            localparam logic [ACC_WIDTH-1:0] DefIncr =
                ACC_WIDTH'(chan_field(PACK_W'(DEFAULT_INCR), i, ACC_WIDTH));
            localparam logic [ACC_WIDTH-1:0] DefPhase =
                ACC_WIDTH'(chan_field(PACK_W'(DEFAULT_PHASE), i, ACC_WIDTH));

            logic load;
            assign load = cfg_write & (cfg_chan == CHAN_W'(i));

            cegen_channel #(
                .ACC_WIDTH (ACC_WIDTH),
                .DEF_INCR  (DefIncr),
                .DEF_PHASE (DefPhase)
            ) u_channel (
                .clk_i        (refclk),
                .rst_i        (rst),
                .load_i       (load),
                .load_incr_i  (cfg_incr),
                .load_phase_i (cfg_phase),
                .realign_i    (state_q == APPLY),
                .run_i        (state_q != APPLY),
                .ce_o         (ce_o[i]),
                .clk_o        (clk_o[i])
            );
        end
    endgenerate

endmodule

// File: tb/tb_clk_enable_gen.sv
// Self-checking bench for clk_enable_gen: directed scenarios plus randomized config traffic,
// all compared against a cycle-level arithmetic model of the NCO channels.
module tb_clk_enable_gen;

    localparam int unsigned NCH   = 3;
    localparam int unsigned ACCW  = 8;
    localparam int unsigned LOCKN = 4;
    localparam int unsigned MODV  = 1 << ACCW;
    localparam logic [NCH*ACCW-1:0] DEF_INCR  = {8'd40, 8'd64, 8'd64};
    localparam logic [NCH*ACCW-1:0] DEF_PHASE = {8'd200, 8'd128, 8'd0};

    logic            refclk = 1'b0;
    logic            rst    = 1'b1;
    logic            cfg_valid = 1'b0;
    logic            cfg_ready;
    logic [1:0]      cfg_chan  = '0;
    logic [ACCW-1:0] cfg_incr  = '0;
    logic [ACCW-1:0] cfg_phase = '0;
    logic [NCH-1:0]  ce_o;
    logic [NCH-1:0]  clk_o;
    logic            locked;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    int unsigned m_incr[NCH];
    int unsigned m_phase[NCH];
    int unsigned m_acc[NCH];
    bit          m_ce[NCH];
    bit          m_clk[NCH];
    bit          m_locked;
    bit          m_applying;
    int unsigned m_run;

    clk_enable_gen #(
        .NUM_CHANNELS  (NCH),
        .ACC_WIDTH     (ACCW),
        .LOCK_CYCLES   (LOCKN),
        .DEFAULT_INCR  (DEF_INCR),
        .DEFAULT_PHASE (DEF_PHASE)
    ) dut (
        .refclk    (refclk),
        .rst       (rst),
        .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready),
        .cfg_chan  (cfg_chan),
        .cfg_incr  (cfg_incr),
        .cfg_phase (cfg_phase),
        .ce_o      (ce_o),
        .clk_o     (clk_o),
        .locked    (locked)
    );

    always #5 refclk = ~refclk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NCH; i++) begin
            m_incr[i]  = int'(DEF_INCR[i*ACCW +: ACCW]);
            m_phase[i] = int'(DEF_PHASE[i*ACCW +: ACCW]);
            m_acc[i]   = m_phase[i];
            m_ce[i]    = 1'b0;
            m_clk[i]   = 1'b0;
        end
        m_locked   = 1'b0;
        m_applying = 1'b0;
        m_run      = 0;
    endtask

    task automatic model_step(input bit v, input int unsigned ch, input int unsigned inc,
                              input int unsigned ph);
        int unsigned s;
        if (m_applying) begin
            for (int i = 0; i < NCH; i++) begin
                m_acc[i] = m_phase[i];
                m_ce[i]  = 1'b0;
                m_clk[i] = (m_phase[i] >= MODV / 2);
            end
            m_applying = 1'b0;
            m_run      = 0;
        end else begin
            for (int i = 0; i < NCH; i++) begin
                if (m_incr[i] != 0) begin
                    s        = m_acc[i] + m_incr[i];
                    m_ce[i]  = (s >= MODV);
                    m_acc[i] = s % MODV;
                    m_clk[i] = (m_acc[i] >= MODV / 2);
                end else begin
                    m_ce[i] = 1'b0;
                end
            end
            if (v && ch < NCH) begin
                m_incr[ch]  = inc;
                m_phase[ch] = ph;
                m_applying  = 1'b1;
                m_locked    = 1'b0;
            end else if (!m_locked) begin
                m_run++;
                if (m_run >= LOCKN) m_locked = 1'b1;
            end
        end
    endtask

    task automatic compare_model();
        logic [NCH-1:0] ce_exp, clk_exp;
        for (int i = 0; i < NCH; i++) begin
            ce_exp[i]  = m_ce[i];
            clk_exp[i] = m_clk[i];
        end
        check_val("ce_o", 32'(ce_o), 32'(ce_exp));
        check_val("clk_o", 32'(clk_o), 32'(clk_exp));
        check_val("locked", 32'(locked), 32'(m_locked));
        check_val("cfg_ready", 32'(cfg_ready), 32'(!m_applying));
    endtask

    task automatic cycle();
        @(posedge refclk);
        #1;
        model_step(cfg_valid, int'(cfg_chan), int'(cfg_incr), int'(cfg_phase));
        compare_model();
    endtask

    task automatic check_reset_outputs(input string tag);
        check_val({tag, "_ce"}, 32'(ce_o), 32'd0);
        check_val({tag, "_clk"}, 32'(clk_o), 32'd0);
        check_val({tag, "_locked"}, 32'(locked), 32'd0);
        check_val({tag, "_ready"}, 32'(cfg_ready), 32'd0);
    endtask

    // Called 1 time unit after an edge; asserts reset between edges and releases it after one edge.
    task automatic do_reset(input string tag);
        #2 rst = 1'b1;
        cfg_valid = 1'b0;
        #1;
        check_reset_outputs(tag);
        model_reset();
        @(posedge refclk);
        #1;
        check_reset_outputs({tag, "_hold"});
        rst = 1'b0;
        #1;
        check_val({tag, "_ready_edge0"}, 32'(cfg_ready), 32'd1);
    endtask

    task automatic write_cfg(input int unsigned ch, input int unsigned inc, input int unsigned ph);
        cfg_valid = 1'b1;
        cfg_chan  = 2'(ch);
        cfg_incr  = ACCW'(inc);
        cfg_phase = ACCW'(ph);
        cycle();
        cfg_valid = 1'b0;
    endtask

    task automatic measure_defaults(input string tag);
        int first_ce0 = 0;
        int first_ce1 = 0;
        int first_lock = 0;
        int hi0 = 0;
        for (int e = 1; e <= 12; e++) begin
            cycle();
            if (ce_o[0] && first_ce0 == 0) first_ce0 = e;
            if (ce_o[1] && first_ce1 == 0) first_ce1 = e;
            if (locked && first_lock == 0) first_lock = e;
            if (e > 4 && clk_o[0]) hi0++;
        end
        check_val({tag, "_first_ce0"}, 32'(first_ce0), 32'd4);
        check_val({tag, "_first_ce1"}, 32'(first_ce1), 32'd2);
        check_val({tag, "_first_lock"}, 32'(first_lock), 32'd4);
        check_val({tag, "_clk0_duty"}, 32'(hi0), 32'd4);
    endtask

    initial begin
        int cnt;
        int ce_edges[$];
        int lock_edge;
        bit clk0_seen;

        model_reset();
        #1;
        check_reset_outputs("por");
        @(posedge refclk);
        #1;
        rst = 1'b0;
        #1;
        check_val("ready_edge0", 32'(cfg_ready), 32'd1);

        // Default channel timing and lock qualification
        measure_defaults("dflt");

        // Fractional rate: 96/256 gives 3 pulses per 8 cycles
        write_cfg(0, 96, 0);
        cycle();
        cnt = 0;
        for (int e = 0; e < 800; e++) begin
            cycle();
            cnt += int'(ce_o[0]);
        end
        check_val("frac_count", 32'(cnt), 32'd300);

        // Reconfigure channel 1 while locked
        write_cfg(1, 32, 0);
        check_val("reconf_lock_drop", 32'(locked), 32'd0);
        check_val("reconf_ready_low", 32'(cfg_ready), 32'd0);
        cycle();
        check_val("reconf_ready_back", 32'(cfg_ready), 32'd1);
        lock_edge = 0;
        for (int e = 1; e <= 40; e++) begin
            cycle();
            if (ce_o[1]) ce_edges.push_back(e);
            if (locked && lock_edge == 0) lock_edge = e;
        end
        check_val("relock_edges", 32'(lock_edge), 32'd4);
        check_val("ce1_first", 32'(ce_edges.size() > 0 ? ce_edges[0] : -1), 32'd8);
        check_val("ce1_period", 32'(ce_edges.size() > 1 ? ce_edges[1] - ce_edges[0] : -1), 32'd8);

        // Out-of-range channel: handshake only
        write_cfg(3, 17, 99);
        check_val("oor_locked", 32'(locked), 32'd1);
        check_val("oor_ready", 32'(cfg_ready), 32'd1);
        for (int e = 0; e < 6; e++) cycle();

        // Zero increment freezes channel 0
        write_cfg(0, 0, 0);
        cycle();
        cnt = 0;
        clk0_seen = 1'b0;
        for (int e = 0; e < 20; e++) begin
            cycle();
            cnt += int'(ce_o[0]);
            clk0_seen |= clk_o[0];
        end
        check_val("frozen_ce0", 32'(cnt), 32'd0);
        check_val("frozen_clk0", 32'(clk0_seen), 32'd0);

        // Reset mid-LOCKING, then mid-APPLY; defaults must come back
        write_cfg(1, 10, 20);
        cycle();
        cycle();
        do_reset("rst_locking");
        measure_defaults("after_rst1");
        write_cfg(2, 77, 5);
        do_reset("rst_apply");
        measure_defaults("after_rst2");

        // Randomized config traffic with occasional resets
        for (int e = 0; e < 600; e++) begin
            if ($urandom_range(0, 99) == 0) begin
                do_reset("rand_rst");
            end else if ($urandom_range(0, 5) == 0) begin
                cfg_valid = 1'b1;
                cfg_chan  = 2'($urandom_range(0, 3));
                cfg_incr  = ($urandom_range(0, 3) == 0) ? '0 : ACCW'($urandom_range(1, MODV - 1));
                cfg_phase = ACCW'($urandom_range(0, MODV - 1));
                cycle();
                cfg_valid = 1'b0;
            end else begin
                cycle();
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
